// File: rtl/edge_event_arbiter.sv
// Round-robin arbiter: per-channel edge events become pending flags offered one at a time.
// Optional per-channel holdoff after each accepted event: define EVT_HOLDOFF_EN.
module edge_event_arbiter #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned HOLDOFF = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         edge_in,
  input  logic                      evt_rdy,
  output logic                      evt_vld,
  output logic [$clog2(NUM_CH)-1:0] evt_ch,
  output logic [NUM_CH-1:0]         pend,
  output logic [7:0]                drop_cnt,
  output logic                      busy
);

  localparam int unsigned ChW = $clog2(NUM_CH);

  typedef enum logic {StIdle, StOffer} state_e;

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [ChW-1:0]    evt_ch_q, evt_ch_d;
  logic [ChW-1:0]    last_grant_q, last_grant_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  logic              hs;
  logic [NUM_CH-1:0] clr_mask;
  logic [NUM_CH-1:0] sup_mask;
  logic [NUM_CH-1:0] acc_mask;
  logic [NUM_CH-1:0] drop_mask;
  logic              sel_found;
  logic [ChW-1:0]    sel_ch;
  int                sel_idx;

  assign hs = (state_q == StOffer) && evt_rdy;

  always_comb begin
    clr_mask = '0;
    if (hs) clr_mask[evt_ch_q] = 1'b1;
  end

`ifdef EVT_HOLDOFF_EN
  logic [7:0] hold_q [NUM_CH];
  logic [7:0] hold_d [NUM_CH];

  // The handshake cycle itself is also suppressed, so a same-cycle re-trigger is ignored.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sup_mask[i] = (hold_q[i] != 8'd0) || clr_mask[i];
      if (clr_mask[i]) begin
        hold_d[i] = 8'(HOLDOFF);
      end else if (hold_q[i] != 8'd0) begin
        hold_d[i] = hold_q[i] - 8'd1;
      end else begin
        hold_d[i] = 8'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst) hold_q[i] <= 8'd0;
      else     hold_q[i] <= hold_d[i];
    end
  end
`else
  logic [7:0] unused_holdoff;
  assign unused_holdoff = 8'(HOLDOFF);
  assign sup_mask       = '0;
`endif

  always_comb begin
    acc_mask  = edge_in & ~sup_mask;
    drop_mask = acc_mask & pend_q & ~clr_mask;
    pend_d    = (pend_q & ~clr_mask) | acc_mask;
    drop_cnt_d = drop_cnt_q;
    if (|drop_mask && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    sel_found = 1'b0;
    sel_ch    = '0;
    sel_idx   = 0;
    for (int k = 1; k <= int'(NUM_CH); k++) begin
      sel_idx = (int'(last_grant_q) + k) % int'(NUM_CH);
      if (!sel_found && pend_q[sel_idx]) begin
        sel_found = 1'b1;
        sel_ch    = ChW'(sel_idx);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    evt_ch_d     = evt_ch_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      StIdle: begin
        if (sel_found) begin
          state_d  = StOffer;
          evt_ch_d = sel_ch;
        end
      end
      StOffer: begin
        if (evt_rdy) begin
          state_d      = StIdle;
          last_grant_d = evt_ch_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      pend_q       <= '0;
      evt_ch_q     <= '0;
      last_grant_q <= ChW'(NUM_CH - 1);
      drop_cnt_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      evt_ch_q     <= evt_ch_d;
      last_grant_q <= last_grant_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign evt_vld  = (state_q == StOffer);
  assign busy     = (state_q == StOffer);
  assign evt_ch   = evt_ch_q;
  assign pend     = pend_q;
  assign drop_cnt = drop_cnt_q;

endmodule
